uart_word_loader: RTL

UART_WORD_LOADER -- requirements
Module: uart_word_loader

---
 rtl/uart_word_loader.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/uart_word_loader.sv
// uart_word_loader: assembles bytes from a UART receiver into 32-bit words and
// writes them to consecutive instruction-memory addresses.
// Stream format: 4-byte little-endian word count L, then L little-endian words.
// Optional feature macro LOADER_CHECKSUM_EN: one trailing byte holding the XOR
// of all payload bytes. A match finishes the load; a mismatch aborts it.
//
// Byte handshake: rx_valid is a one-cycle pulse qualifying rx_data/rx_ferr.
// Every pulse is consumed on the clock edge where it is seen. There is no
// back-pressure. mem_we is a one-cycle strobe with mem_addr/mem_wdata stable
// while it is high.
module uart_word_loader #(
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   input  logic              rx_ferr,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              load_done,
   output logic              load_err,
   output logic              busy,
   output logic [2:0]        dbg_state_o
);

   typedef enum logic [2:0] {
      S_HDR  = 3'd0,
      S_DATA = 3'd1,
`ifdef LOADER_CHECKSUM_EN
      S_CSUM = 3'd2,
`endif
      S_DONE = 3'd3,
      S_ERR  = 3'd4
   } state_t;

   // The state that follows the last payload word.
`ifdef LOADER_CHECKSUM_EN
   localparam state_t S_END = S_CSUM;
`else
   localparam state_t S_END = S_DONE;
`endif

   // Largest legal word count: the memory holds 2^ADDR_W words.
   localparam logic [32:0] LEN_CAP = 33'd1 << ADDR_W;

   state_t            state_q, state_d;
   logic [1:0]        cnt_q;
   logic [23:0]       shift_q;
   logic [31:0]       len_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic              we_q;
   logic              started_q;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]        xor_q;
`endif

   logic        active;
   logic        byte_ok;
   logic        byte_bad;
   logic        last_byte;
   logic        last_word;
   logic [31:0] word;

   // Bytes are accepted only while a load is still in progress.
   assign active    = (state_q == S_HDR) || (state_q == S_DATA)
`ifdef LOADER_CHECKSUM_EN
                      || (state_q == S_CSUM)
`endif
                      ;
   assign byte_ok   = rx_valid && !rx_ferr && active;
   assign byte_bad  = rx_valid && rx_ferr && active;
   assign last_byte = (cnt_q == 2'd3);
   // The three earlier bytes sit in shift_q. The newest byte is the top byte.
   assign word      = {rx_data, shift_q};
   assign last_word = ((33'(addr_q) + 33'd1) == {1'b0, len_q});

   // State register.
   always_ff @(posedge clk) begin
      if (!rstn) state_q <= S_HDR;
      else       state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_HDR: begin
            if (byte_bad)
               state_d = S_ERR;
            else if (byte_ok && last_byte) begin
               if (word == 32'd0)                  state_d = S_END;
               else if ({1'b0, word} > LEN_CAP)    state_d = S_ERR;
               else                                state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (byte_bad)
               state_d = S_ERR;
            else if (byte_ok && last_byte && last_word)
               state_d = S_END;
         end
`ifdef LOADER_CHECKSUM_EN
         S_CSUM: begin
            if (byte_bad)
               state_d = S_ERR;
            else if (byte_ok)
               state_d = (rx_data == xor_q) ? S_DONE : S_ERR;
         end
`endif
         default: state_d = state_q;
      endcase
   end

   // Outputs decoded from state. Both flags are sticky because only reset leaves DONE or ERR.
   always_comb begin
      load_done   = (state_q == S_DONE);
      load_err    = (state_q == S_ERR);
      busy        = started_q && active;
      dbg_state_o = state_q;
   end

   // Byte assembly, write strobe and address counter.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt_q     <= 2'd0;
         shift_q   <= 24'd0;
         len_q     <= 32'd0;
         addr_q    <= '0;
         wdata_q   <= 32'd0;
         we_q      <= 1'b0;
         started_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         xor_q     <= 8'd0;
`endif
      end else begin
         we_q <= 1'b0;
         // Advance after a write unless it was the last one. This keeps
         // mem_addr frozen once the load has finished.
         if (we_q && state_q == S_DATA)
            addr_q <= addr_q + ADDR_W'(1);
         if (byte_ok) begin
            started_q <= 1'b1;
            cnt_q     <= cnt_q + 2'd1;
            shift_q   <= {rx_data, shift_q[23:8]};
            if (state_q == S_HDR && last_byte)
               len_q <= word;
            if (state_q == S_DATA) begin
`ifdef LOADER_CHECKSUM_EN
               xor_q <= xor_q ^ rx_data;
`endif
               if (last_byte) begin
                  we_q    <= 1'b1;
                  wdata_q <= word;
               end
            end
         end
      end
   end

   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

endmodule
